irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller that sits directly upstream of the cpu core.
- Collects NSRC external interrupt lines, synchronises them and latches edges into pending bits.
- Drives the core's irq input.
- Slaves on the core's data bus (wr, addr_out, data_out, wr_mask) and returns register contents on mrd.

Parameters:
- NSRC, 8, number of interrupt sources (1..32).
- BASE_ADDR, 32'hFFFF_FF00, register window base; window is 256 bytes, decoded on addr_out[31:8].

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low (reset=0 clears all state immediately).
- src  in  NSRC  raw interrupt lines, asynchronous to clk.
- wr  in  1  core write strobe.
- addr_out  in  32  core data address.
- data_out  in  32  core write data.
- wr_mask  in  16  core write mask; bits [3:0] are byte enables for data_out[31:0], bits [15:4] ignored.
- mrd  out  32  read data to core; combinational from addr_out.
- irq  out  1  interrupt request to core; registered.

Behaviour:
- Register map, offsets from BASE_ADDR:
  - 0x00 PENDING: R; write-1-to-clear.
  - 0x04 ENABLE: RW.
  - 0x08 TYPE: RW; 1 = edge, 0 = level.
  - 0x0C CTRL: RW; bit0 = global enable.
  - 0x10 CLAIM: R; {valid, 26'b0, id[4:0]}. A write of id clears PENDING[id] when the id is an edge source.
  - All other offsets read 0; writes to them are ignored.
- Bits at and above NSRC read 0 and are not writable.
- Select: sel = (addr_out[31:8] == BASE_ADDR[31:8]).
  - mrd = register at addr_out[7:0] when sel, else 32'h0.
  - Address bits [1:0] are ignored.
- Writes act only when wr && sel.
  - Each byte lane k updates only if wr_mask[k].
  - W1C to PENDING and CLAIM writes apply only when wr_mask[0] is set for bits [7:0], and likewise for the other lanes.
- Reset values: PENDING=0, ENABLE=0, TYPE=all-ones (edge), CTRL=0, sync/edge flops=0, irq=0.
- Per source: two-flop synchroniser, then a previous-value flop. A rise means sync2 && !prev.
- Edge source:
  - PENDING[i] sets on a rise.
  - It clears on W1C or a CLAIM write.
  - A rise in the same cycle as a clear leaves the bit set (set wins).
- Level source: PENDING[i] = sync2 each cycle. W1C and CLAIM writes have no effect.
- Latency:
  - src[i] rises and is sampled at edge N; sync2 is high after N+1.
  - PENDING set after N+2; irq high after N+3.
- irq register next = CTRL[0] && |(PENDING & ENABLE).
- CLAIM.id is the lowest-index bit of PENDING & ENABLE; valid=1 when any bit is set, else the register reads 0.
- Changing TYPE edge→level: the bit takes the level value the next cycle.
- Changing TYPE level→edge: the bit is cleared the next cycle, and only subsequent rises set it.
- Reset asserted mid-operation clears everything asynchronously; irq drops in the same cycle.
- Pulses shorter than one clk period may be missed; this is documented, not a bug.

Decomposition:
- Shared package irq_ctrl_pkg holds:
  - register offset constants: OFS_PENDING, OFS_ENABLE, OFS_TYPE, OFS_CTRL, OFS_CLAIM;
  - CLAIM field positions: CLAIM_VALID_BIT=31, CLAIM_ID_W=5.
- Sub-module irq_sync_edge:
  - 2-flop synchroniser plus prev flop per line.
  - Outputs level and rise.
  - Generated NSRC times.
- The top holds the registers, decode, priority encoder and irq flop.

Test Plan:
- Reset: hold reset=0 with src=8'hFF. Required: irq=0; reads give PENDING=0, TYPE=32'hFF, ENABLE=0.
- Edge path: write ENABLE=8'h04 and CTRL=1, then pulse src[2] high for 3 cycles. Required: PENDING=32'h04 after 2 edges, irq=1 on the 3rd edge, CLAIM=32'h8000_0002. Writing CLAIM=2 drops irq one cycle later.
- Priority and W1C: pend src[5] and src[1] with ENABLE=8'hFF. Required: CLAIM reads id 1. Writing PENDING=32'h02 with wr_mask=16'h0001 makes CLAIM read id 5. Writing PENDING=32'h20 with wr_mask=16'h0002 (wrong lane) leaves PENDING unchanged.
- Set-wins collision: a rise on src[3] lands in the same cycle as a W1C of bit 3. Required: PENDING[3] stays 1.
- Level mode: TYPE=8'hFE, ENABLE=1, CTRL=1, src[0] held high. Required: PENDING[0] follows src[0] with 2-cycle lag, W1C has no effect, and irq falls 3 cycles after src[0] falls.
- Decode and reset: addr_out=32'h0000_0010 gives mrd=0, and a write there leaves all registers unchanged. Pulling reset low while irq=1 forces irq=0 before the next clk edge.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the memory-mapped interrupt controller:
// register offsets, CLAIM field layout and a byte-lane helper.
package irq_ctrl_pkg;

    localparam logic [7:0] OFS_PENDING = 8'h00;
    localparam logic [7:0] OFS_ENABLE  = 8'h04;
    localparam logic [7:0] OFS_TYPE    = 8'h08;
    localparam logic [7:0] OFS_CTRL    = 8'h0C;
    localparam logic [7:0] OFS_CLAIM   = 8'h10;

    localparam int CLAIM_VALID_BIT = 31;
    localparam int CLAIM_ID_W      = 5;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line two-flop synchroniser followed by a previous-value flop;
// exposes the synchronised level and a single-cycle rise strobe.
module irq_sync_edge #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    output logic [NSRC-1:0] level,
    output logic [NSRC-1:0] rise
);

    for (genvar i = 0; i < NSRC; i++) begin : g_line
        logic s1;
        logic s2;
        logic prev;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1   <= 1'b0;
                s2   <= 1'b0;
                prev <= 1'b0;
            end else begin
                s1   <= src[i];
                s2   <= s1;
                prev <= s2;
            end
        end

        assign level[i] = s2;
        assign rise[i]  = s2 & ~prev;
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller top: register file, bus decode, pending logic,
// lowest-index claim encoder and the registered irq output.
module irq_ctrl #(
    parameter int          NSRC      = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            wr,
    input  logic [31:0]     addr_out,
    input  logic [31:0]     data_out,
    input  logic [15:0]     wr_mask,
    output logic [31:0]     mrd,
    output logic            irq
);
    import irq_ctrl_pkg::*;

    localparam logic [32:0] ONE33    = 33'd1;
    localparam logic [31:0] SRC_MASK = 32'((ONE33 << NSRC) - ONE33);

    logic [NSRC-1:0] level;
    logic [NSRC-1:0] rise;

    logic [31:0] lvl32;
    logic [31:0] rise32;
    logic [31:0] pending;
    logic [31:0] enable;
    logic [31:0] type_q;
    logic        ctrl_en;

    logic        sel;
    logic        we;
    logic [7:0]  ofs;
    logic [31:0] be;
    logic [31:0] wbits;
    logic [31:0] clr;
    logic [31:0] type_next;
    logic [31:0] to_edge;
    logic [31:0] pend_next;
    logic [31:0] act;
    logic [31:0] claim;
    logic [CLAIM_ID_W-1:0] claim_id;
    logic        unused_bits;

    irq_sync_edge #(.NSRC(NSRC)) u_sync (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .level (level),
        .rise  (rise)
    );

    assign lvl32  = 32'(level);
    assign rise32 = 32'(rise);

    assign sel   = (addr_out[31:8] == BASE_ADDR[31:8]);
    assign we    = wr && sel;
    assign ofs   = {addr_out[7:2], 2'b00};
    assign be    = lane_mask(wr_mask[3:0]);
    assign wbits = data_out & be;

    assign unused_bits = ^{wr_mask[15:4], addr_out[1:0]};

    always_comb begin
        clr       = '0;
        type_next = type_q;
        if (we && ofs == OFS_PENDING) begin
            clr = wbits;
        end
        if (we && ofs == OFS_CLAIM && wr_mask[0]) begin
            clr[data_out[4:0]] = 1'b1;
        end
        if (we && ofs == OFS_TYPE) begin
            type_next = ((type_q & ~be) | wbits) & SRC_MASK;
        end
        // a bit switching level->edge drops its stale level value
        to_edge   = type_next & ~type_q;
        pend_next = (type_q & ((pending & ~clr) | rise32))
                  | (~type_q & lvl32);
        pend_next = pend_next & ~to_edge & SRC_MASK;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            enable  <= '0;
            type_q  <= SRC_MASK;
            ctrl_en <= 1'b0;
            irq     <= 1'b0;
        end else begin
            pending <= pend_next;
            type_q  <= type_next;
            if (we && ofs == OFS_ENABLE) begin
                enable <= ((enable & ~be) | wbits) & SRC_MASK;
            end
            if (we && ofs == OFS_CTRL && wr_mask[0]) begin
                ctrl_en <= data_out[0];
            end
            irq <= ctrl_en && |(pending & enable);
        end
    end

    always_comb begin
        act      = pending & enable;
        claim_id = '0;
        for (int i = 31; i >= 0; i--) begin
            if (act[i]) begin
                claim_id = CLAIM_ID_W'(i);
            end
        end
        claim                   = '0;
        claim[CLAIM_VALID_BIT]  = |act;
        claim[CLAIM_ID_W-1:0]   = claim_id;
    end

    always_comb begin
        mrd = '0;
        if (sel) begin
            case (ofs)
                OFS_PENDING: mrd = pending;
                OFS_ENABLE:  mrd = enable;
                OFS_TYPE:    mrd = type_q;
                OFS_CTRL:    mrd = {31'b0, ctrl_en};
                OFS_CLAIM:   mrd = claim;
                default:     mrd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: decode table, directed corner sequences and a
// randomized run checked against a cycle-level reference model.
module tb_irq_ctrl;

    localparam logic [31:0] B = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  src = '0;
    logic        wr = 1'b0;
    logic [31:0] addr_out = '0;
    logic [31:0] data_out = '0;
    logic [15:0] wr_mask = '0;
    logic [31:0] mrd;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    irq_ctrl #(.NSRC(8), .BASE_ADDR(32'hFFFF_FF00)) dut (
        .clk      (clk),
        .reset    (reset),
        .src      (src),
        .wr       (wr),
        .addr_out (addr_out),
        .data_out (data_out),
        .wr_mask  (wr_mask),
        .mrd      (mrd),
        .irq      (irq)
    );

    // reference model state; hs0/hs1/hs2 = src samples 1/2/3 edges ago
    logic [7:0] m_pend, m_en, m_type;
    logic       m_ctrl, m_irq;
    logic [7:0] hs0, hs1, hs2;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic m_reset();
        m_pend = '0; m_en = '0; m_type = 8'hFF;
        m_ctrl = 1'b0; m_irq = 1'b0;
        hs0 = '0; hs1 = '0; hs2 = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [7:0]  act;
        logic [31:0] r;
        r = '0;
        act = m_pend & m_en;
        if (a[31:8] != B[31:8]) return '0;
        case (a[7:2])
            6'd0: r = {24'h0, m_pend};
            6'd1: r = {24'h0, m_en};
            6'd2: r = {24'h0, m_type};
            6'd3: r = {31'h0, m_ctrl};
            6'd4: for (int i = 7; i >= 0; i--)
                      if (act[i]) r = 32'h8000_0000 | 32'(i);
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic m_edge(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [15:0] m,
                          input logic [7:0] s);
        logic [7:0] be8, wb, clr, lvl, rs, nt, np;
        logic hit, nirq;
        hit = w && (a[31:8] == B[31:8]);
        lvl = hs1;
        rs  = hs1 & ~hs2;
        be8 = {8{m[0]}};
        wb  = d[7:0] & be8;
        clr = '0;
        nt  = m_type;
        nirq = m_ctrl && ((m_pend & m_en) != 8'h0);
        if (hit) begin
            case (a[7:2])
                6'd0: clr = wb;
                6'd1: m_en = (m_en & ~be8) | wb;
                6'd2: nt = (m_type & ~be8) | wb;
                6'd3: if (m[0]) m_ctrl = d[0];
                6'd4: if (m[0] && d[4:0] < 5'd8) clr[d[2:0]] = 1'b1;
                default: ;
            endcase
        end
        for (int i = 0; i < 8; i++) begin
            if (!m_type[i] && nt[i]) np[i] = 1'b0;
            else if (m_type[i]) np[i] = (m_pend[i] && !clr[i]) || rs[i];
            else np[i] = lvl[i];
        end
        m_pend = np;
        m_type = nt;
        m_irq  = nirq;
        hs2 = hs1; hs1 = hs0; hs0 = s;
    endtask

    task automatic step();
        logic w, rs;
        logic [31:0] a, d;
        logic [15:0] m;
        logic [7:0] s;
        w = wr; a = addr_out; d = data_out; m = wr_mask; s = src;
        rs = reset;
        @(posedge clk);
        if (!rs || !reset) m_reset();
        else m_edge(w, a, d, m, s);
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d,
                          input logic [15:0] m);
        wr = 1'b1; addr_out = a; data_out = d; wr_mask = m;
        step();
        wr = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [31:0] a,
                          input logic [31:0] exp);
        wr = 1'b0;
        addr_out = a;
        #1;
        chk(name, mrd, exp);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] a;
        a = B | 32'($urandom_range(0, 6) * 4) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = $urandom;
        return a;
    endfunction

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [15:0] m;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[15];

    initial begin
        tv[0]  = '{1'b1, B+32'h04, 32'h0000_00A5, 16'h000F, B+32'h04, 32'hA5};
        tv[1]  = '{1'b1, B+32'h04, 32'hFFFF_FF3C, 16'h0001, B+32'h04, 32'h3C};
        tv[2]  = '{1'b1, B+32'h04, 32'h0000_1200, 16'h0002, B+32'h04, 32'h3C};
        tv[3]  = '{1'b1, B+32'h08, 32'h0000_000F, 16'h0000, B+32'h08, 32'hFF};
        tv[4]  = '{1'b1, B+32'h08, 32'h0000_00F0, 16'h0001, B+32'h08, 32'hF0};
        tv[5]  = '{1'b1, B+32'h0C, 32'hFFFF_FFFF, 16'h000F, B+32'h0C, 32'h01};
        tv[6]  = '{1'b1, 32'h0000_0004, 32'h0, 16'h000F, B+32'h04, 32'h3C};
        tv[7]  = '{1'b1, B+32'h20, 32'hFF, 16'h000F, B+32'h20, 32'h0};
        tv[8]  = '{1'b0, B, 32'h0, 16'h0, B+32'h07, 32'h3C};
        tv[9]  = '{1'b0, B, 32'h0, 16'h0, 32'h0000_0010, 32'h0};
        tv[10] = '{1'b1, B+32'h08, 32'hFF, 16'h0001, B+32'h08, 32'hFF};
        tv[11] = '{1'b1, B+32'h0C, 32'h0, 16'h0001, B+32'h0C, 32'h0};
        tv[12] = '{1'b1, B+32'h04, 32'h0, 16'h000F, B+32'h04, 32'h0};
        tv[13] = '{1'b1, B, 32'hFF, 16'h000F, B, 32'h0};
        tv[14] = '{1'b0, B, 32'h0, 16'h0, B+32'h10, 32'h0};

        m_reset();

        // reset state with all lines high
        reset = 1'b0;
        src = 8'hFF;
        steps(3);
        chk("rst_irq", irq, 0);
        chk_rd("rst_pending", B, 32'h0);
        chk_rd("rst_type", B + 32'h08, 32'hFF);
        chk_rd("rst_enable", B + 32'h04, 32'h0);
        src = 8'h00;
        step();
        reset = 1'b1;
        step();

        // decode / byte-lane table
        for (int i = 0; i < 15; i++) begin
            wr = tv[i].w; addr_out = tv[i].a;
            data_out = tv[i].d; wr_mask = tv[i].m;
            step();
            wr = 1'b0;
            chk_rd($sformatf("vec%0d", i), tv[i].ra, tv[i].exp);
        end

        // edge path
        wr_reg(B + 32'h04, 32'h04, 16'h000F);
        wr_reg(B + 32'h0C, 32'h01, 16'h000F);
        src = 8'h04;
        steps(3);
        chk_rd("edge_pending", B, 32'h04);
        chk("edge_irq_early", irq, 0);
        src = 8'h00;
        step();
        chk("edge_irq", irq, 1);
        chk_rd("edge_claim", B + 32'h10, 32'h8000_0002);
        wr_reg(B + 32'h10, 32'h2, 16'h000F);
        chk("claim_irq_hold", irq, 1);
        chk_rd("claim_clear", B, 32'h0);
        step();
        chk("claim_irq_drop", irq, 0);

        // priority and W1C lanes
        wr_reg(B + 32'h04, 32'hFF, 16'h000F);
        src = 8'h22;
        steps(3);
        src = 8'h00;
        steps(3);
        chk_rd("prio_claim1", B + 32'h10, 32'h8000_0001);
        chk("prio_irq", irq, 1);
        wr_reg(B, 32'h02, 16'h0001);
        chk_rd("prio_claim5", B + 32'h10, 32'h8000_0005);
        wr_reg(B, 32'h20, 16'h0002);
        chk_rd("w1c_wrong_lane", B, 32'h20);
        wr_reg(B, 32'h20, 16'h0001);
        chk_rd("w1c_clear", B, 32'h0);

        // set wins over a same-cycle W1C
        src = 8'h08;
        steps(3);
        src = 8'h00;
        steps(3);
        chk_rd("collide_pre", B, 32'h08);
        src = 8'h08;
        steps(2);
        wr_reg(B, 32'h08, 16'h0001);
        chk_rd("collide_set_wins", B, 32'h08);
        src = 8'h00;
        steps(3);
        wr_reg(B, 32'h08, 16'h0001);
        chk_rd("collide_cleared", B, 32'h0);

        // level mode
        wr_reg(B + 32'h04, 32'h01, 16'h000F);
        wr_reg(B + 32'h08, 32'hFE, 16'h000F);
        src = 8'h01;
        steps(2);
        chk_rd("lvl_lag", B, 32'h0);
        step();
        chk_rd("lvl_set", B, 32'h01);
        step();
        chk("lvl_irq", irq, 1);
        wr_reg(B, 32'h01, 16'h000F);
        chk_rd("lvl_w1c_noeffect", B, 32'h01);
        src = 8'h00;
        steps(3);
        chk_rd("lvl_fall", B, 32'h0);
        chk("lvl_irq_hold", irq, 1);
        step();
        chk("lvl_irq_fall", irq, 0);
        wr_reg(B + 32'h08, 32'hFF, 16'h000F);

        // outside-window write leaves registers alone
        wr_reg(32'h0000_0010, 32'hFFFF_FFFF, 16'h000F);
        chk_rd("out_mrd", 32'h0000_0010, 32'h0);
        chk_rd("out_enable", B + 32'h04, m_read(B + 32'h04));
        chk_rd("out_type", B + 32'h08, m_read(B + 32'h08));
        chk_rd("out_ctrl", B + 32'h0C, m_read(B + 32'h0C));

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            logic [31:0] ra;
            chk("rnd_irq", irq, m_irq);
            ra = pick();
            chk_rd("rnd_mrd", ra, m_read(ra));
            if ($urandom_range(0, 3) == 0) begin
                wr = 1'b1;
                addr_out = pick();
                data_out = $urandom;
                wr_mask = 16'($urandom);
                if (addr_out[7:2] == 6'd4)
                    data_out[4:0] = 5'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 2) == 0) src = 8'($urandom);
            step();
            wr = 1'b0;
        end
        src = 8'h00;
        steps(4);

        // asynchronous reset while irq is high
        wr_reg(B + 32'h08, 32'hFF, 16'h000F);
        wr_reg(B + 32'h04, 32'h04, 16'h000F);
        wr_reg(B + 32'h0C, 32'h01, 16'h000F);
        src = 8'h04;
        steps(3);
        src = 8'h00;
        step();
        chk("pre_reset_irq", irq, 1);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_irq", irq, 0);
        chk_rd("async_reset_pending", B, 32'h0);
        m_reset();
        step();
        reset = 1'b1;
        steps(4);
        chk("post_reset_irq", irq, 0);
        chk_rd("post_reset_enable", B + 32'h04, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
